// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: accepts a bit-reversed-order FFT frame stream and
// re-emits each frame in natural order, back-to-back frames at full rate.
module fft_bitrev_reorder #(
   parameter int unsigned N     = 1024,
   parameter int unsigned LOG2N = 10,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di_re,
   input  logic [WIDTH-1:0] di_im,
   output logic             do_en,
   output logic [WIDTH-1:0] do_re,
   output logic [WIDTH-1:0] do_im,
   output logic             do_last
);

   localparam int unsigned DW = 2 * WIDTH;
   localparam logic [LOG2N-1:0] LAST_ADDR = LOG2N'(N - 1);

   typedef enum logic {ST_IDLE, ST_READ} state_e;

   logic [DW-1:0]    mem0 [N];
   logic [DW-1:0]    mem1 [N];

   logic [LOG2N-1:0] wcnt_q, wcnt_d;
   logic             wbank_q, wbank_d;
   logic [1:0]       full_q, full_d;
   state_e           state_q, state_d;
   logic             rbank_q, rbank_d;
   logic [LOG2N-1:0] rcnt_q, rcnt_d;
   logic             do_en_q, do_en_d;
   logic             do_last_q, do_last_d;
   logic [DW-1:0]    do_data_q, do_data_d;

   logic             wr_done;
   logic             rd_en;
   logic             rd_done;
   logic             rd_bank;
   logic [LOG2N-1:0] rd_addr;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

   // Write side: counter walks input positions, bank swaps on frame completion
   always_comb begin
      wcnt_d  = wcnt_q;
      wbank_d = wbank_q;
      wr_done = 1'b0;
      if (di_en) begin
         wcnt_d = wcnt_q + LOG2N'(1);
         if (wcnt_q == LAST_ADDR) begin
            wcnt_d  = '0;
            wr_done = 1'b1;
            wbank_d = ~wbank_q;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (di_en && !wbank_q) mem0[bitrev(wcnt_q)] <= {di_re, di_im};
      if (di_en &&  wbank_q) mem1[bitrev(wcnt_q)] <= {di_re, di_im};
   end

   // Read FSM: IDLE issues address 0 immediately so output starts 2 cycles after the last input
   always_comb begin
      state_d = state_q;
      rbank_d = rbank_q;
      rcnt_d  = rcnt_q;
      rd_en   = 1'b0;
      rd_done = 1'b0;
      rd_bank = rbank_q;
      rd_addr = rcnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|full_q) begin
               rd_en   = 1'b1;
               rd_bank = full_q[wbank_q] ? wbank_q : ~wbank_q;
               rd_addr = '0;
               rbank_d = rd_bank;
               rcnt_d  = LOG2N'(1);
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            rd_en  = 1'b1;
            rcnt_d = rcnt_q + LOG2N'(1);
            if (rcnt_q == LAST_ADDR) begin
               rd_done = 1'b1;
               rcnt_d  = '0;
               if (full_q[~rbank_q] || (wr_done && (wbank_q != rbank_q))) begin
                  rbank_d = ~rbank_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      full_d = full_q;
      if (rd_done) full_d[rbank_q] = 1'b0;
      if (wr_done) full_d[wbank_q] = 1'b1;
   end

   // Registered read doubles as the output register; data holds when idle
   always_comb begin
      do_en_d   = rd_en;
      do_last_d = rd_en && (rd_addr == LAST_ADDR);
      do_data_d = do_data_q;
      if (rd_en) begin
         do_data_d = rd_bank ? mem1[rd_addr] : mem0[rd_addr];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wcnt_q    <= '0;
         wbank_q   <= 1'b0;
         full_q    <= '0;
         state_q   <= ST_IDLE;
         rbank_q   <= 1'b0;
         rcnt_q    <= '0;
         do_en_q   <= 1'b0;
         do_last_q <= 1'b0;
         do_data_q <= '0;
      end else begin
         wcnt_q    <= wcnt_d;
         wbank_q   <= wbank_d;
         full_q    <= full_d;
         state_q   <= state_d;
         rbank_q   <= rbank_d;
         rcnt_q    <= rcnt_d;
         do_en_q   <= do_en_d;
         do_last_q <= do_last_d;
         do_data_q <= do_data_d;
      end
   end

   assign do_en   = do_en_q;
   assign do_last = do_last_q;
   assign do_re   = do_data_q[DW-1:WIDTH];
   assign do_im   = do_data_q[WIDTH-1:0];

   // A bank still awaiting readout must never be overwritten
   a_no_overrun: assert property (@(posedge clock) disable iff (!reset)
                                  !(di_en && full_q[wbank_q]));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench: one input stream drives a 1024-point and a 16-point
// reorder buffer; a reference model predicts value, do_last and arrival cycle.
module tb_fft_bitrev_reorder;

   localparam int unsigned NL = 1024;
   localparam int unsigned LL = 10;
   localparam int unsigned NS = 16;
   localparam int unsigned LS = 4;
   localparam int unsigned W  = 32;

   typedef struct packed {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic         last;
      logic [31:0]  stamp;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         di_en = 1'b0;
   logic [W-1:0] di_re = '0;
   logic [W-1:0] di_im = '0;
   logic         do_en_l, do_last_l, do_en_s, do_last_s;
   logic [W-1:0] do_re_l, do_im_l, do_re_s, do_im_s;

   logic [31:0]  ecnt = 0;
   int           n_vec = 0;
   int           n_err = 0;
   exp_t         exp_l[$];
   exp_t         exp_s[$];
   logic [2*W-1:0] fr_l[$];
   logic [2*W-1:0] fr_s[$];
   exp_t         el, es;

   fft_bitrev_reorder #(.N(NL), .LOG2N(LL), .WIDTH(W)) u_dut_l (
      .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .do_en(do_en_l), .do_re(do_re_l), .do_im(do_im_l), .do_last(do_last_l));

   fft_bitrev_reorder #(.N(NS), .LOG2N(LS), .WIDTH(W)) u_dut_s (
      .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .do_en(do_en_s), .do_re(do_re_s), .do_im(do_im_s), .do_last(do_last_s));

   always #5 clock = ~clock;
   always @(posedge clock) ecnt <= ecnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, ecnt);
      end
   endtask

   function automatic int unsigned rev(input int unsigned x, input int unsigned bits);
      int unsigned r = 0;
      int unsigned v = x;
      for (int b = 0; b < bits; b++) begin
         r = r * 2 + v % 2;
         v = v / 2;
      end
      return r;
   endfunction

   // Reference model: collect a frame, then output k is input position rev(k)
   task automatic accept(input logic [W-1:0] re, input logic [W-1:0] im);
      logic [31:0] st;
      int unsigned i;
      st = ecnt + 32'd2;
      fr_l.push_back({re, im});
      fr_s.push_back({re, im});
      if (fr_l.size() == NL) begin
         for (int unsigned k = 0; k < NL; k++) begin
            i = rev(k, LL);
            exp_l.push_back('{re: fr_l[i][2*W-1:W], im: fr_l[i][W-1:0],
                              last: (k == NL - 1), stamp: st + 32'(k)});
         end
         fr_l.delete();
      end
      if (fr_s.size() == NS) begin
         for (int unsigned k = 0; k < NS; k++) begin
            i = rev(k, LS);
            exp_s.push_back('{re: fr_s[i][2*W-1:W], im: fr_s[i][W-1:0],
                              last: (k == NS - 1), stamp: st + 32'(k)});
         end
         fr_s.delete();
      end
   endtask

   task automatic send(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
      @(negedge clock);
      di_en = en;
      di_re = re;
      di_im = im;
      if (en) accept(re, im);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) send(1'b0, di_re, di_im);
   endtask

   task automatic rand_frame();
      for (int j = 0; j < NL; j++) send(1'b1, $urandom, $urandom);
   endtask

   task automatic do_reset(input string name);
      @(negedge clock);
      di_en = 1'b0;
      reset = 1'b0;
      fr_l.delete();
      fr_s.delete();
      exp_l.delete();
      exp_s.delete();
      #1;
      chk({name, "_do_en_l"},   64'(do_en_l),   64'd0);
      chk({name, "_do_last_l"}, 64'(do_last_l), 64'd0);
      chk({name, "_do_en_s"},   64'(do_en_s),   64'd0);
      chk({name, "_do_last_s"}, 64'(do_last_s), 64'd0);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      int cyc;
      cyc = 0;
      idle(1);
      while ((exp_l.size() != 0 || exp_s.size() != 0) && cyc < 3000) begin
         @(negedge clock);
         cyc++;
      end
      n_vec++;
      if (exp_l.size() != 0 || exp_s.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: pending outputs got %0d/%0d expected 0/0",
                  name, exp_l.size(), exp_s.size());
      end
   endtask

   // Monitors: every do_en cycle must match the next predicted output, on time
   always @(posedge clock) begin
      #1;
      if (do_en_l) begin
         if (exp_l.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL L_unexpected: got do_en=1 re=%0h expected do_en=0", do_re_l);
         end else begin
            el = exp_l.pop_front();
            chk("L_re",   64'(do_re_l),   64'(el.re));
            chk("L_im",   64'(do_im_l),   64'(el.im));
            chk("L_last", 64'(do_last_l), 64'(el.last));
            chk("L_time", 64'(ecnt),      64'(el.stamp));
         end
      end else begin
         chk("L_last_idle", 64'(do_last_l), 64'd0);
      end
   end

   always @(posedge clock) begin
      #1;
      if (do_en_s) begin
         if (exp_s.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL S_unexpected: got do_en=1 re=%0h expected do_en=0", do_re_s);
         end else begin
            es = exp_s.pop_front();
            chk("S_re",   64'(do_re_s),   64'(es.re));
            chk("S_im",   64'(do_im_s),   64'(es.im));
            chk("S_last", 64'(do_last_s), 64'(es.last));
            chk("S_time", 64'(ecnt),      64'(es.stamp));
         end
      end else begin
         chk("S_last_idle", 64'(do_last_s), 64'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int sent;
      #12;
      chk("init_do_en_l", 64'(do_en_l), 64'd0);
      chk("init_do_re_l", 64'(do_re_l), 64'd0);
      chk("init_do_im_l", 64'(do_im_l), 64'd0);
      chk("init_do_en_s", 64'(do_en_s), 64'd0);
      chk("init_do_re_s", 64'(do_re_s), 64'd0);
      chk("init_do_im_s", 64'(do_im_s), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      idle(3);

      // single ramp frame: do_re[k] = bitrev(k), do_im = 1023 - do_re
      for (int j = 0; j < NL; j++) send(1'b1, 32'(j), 32'(NL - 1 - j));
      wait_drain("single");

      // four back-to-back frames must stream out without a gap
      for (int f = 0; f < 4; f++)
         for (int j = 0; j < NL; j++) send(1'b1, 32'(f * 4096 + j), $urandom);
      wait_drain("b2b");

      // one sample every third cycle
      for (int j = 0; j < NL; j++) begin
         send(1'b1, $urandom, $urandom);
         idle(2);
      end
      wait_drain("gapped");

      // reset in the middle of a fill discards the partial frame
      for (int j = 0; j < 500; j++) send(1'b1, $urandom, $urandom);
      do_reset("rst_fill");
      rand_frame();
      wait_drain("after_rst_fill");

      // reset in the middle of readout aborts output at once
      rand_frame();
      idle(1);
      cyc = 0;
      while (exp_l.size() > NL - 301 && cyc < 3000) begin
         @(negedge clock);
         cyc++;
      end
      n_vec++;
      if (exp_l.size() > NL - 301) begin
         n_err++;
         $display("FAIL rst_read_wait: pending got %0d expected <= %0d", exp_l.size(), NL - 301);
      end
      do_reset("rst_read");
      idle(100);
      rand_frame();
      wait_drain("after_rst_read");

      // random gaps over two frames
      sent = 0;
      while (sent < 2 * NL) begin
         if ($urandom_range(0, 2) != 0) begin
            send(1'b1, $urandom, $urandom);
            sent++;
         end else begin
            idle(1);
         end
      end
      wait_drain("random_gaps");

      idle(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
